ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide engine in the EX stage. It consumes the instruction held in the ID/EX pipeline register together with the post-forwarding operands. While it works, it stalls IF/ID/ID-EX through the hazard unit. It presents a one-cycle result to the EX result mux for EX/MEM capture.
- Radix-2 engine: 32 iterations for MUL* and DIV*/REM*.
- Divide special cases take a one-cycle fast path.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  pipeline flush (branch taken); aborts operation
ex_aluop  in  2  ALU op class from ID/EX; 2'b10 = R-type
ex_funct7  in  7  funct7 from ID/EX; 7'h01 selects M-extension
ex_funct3  in  3  M op: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
ex_rd  in  5  destination register of the EX instruction
op_a  in  32  rs1 operand after forwarding mux
op_b  in  32  rs2 operand after forwarding mux
md_stall  out  1  stall request to hazard unit (holds PC, IF/ID, ID/EX)
md_done  out  1  result valid, exactly one cycle
md_result  out  32  result, valid when md_done
md_rd  out  5  rd of completed op, valid when md_done
md_busy  out  1  engine not in IDLE

Behaviour:
- start = (state==IDLE) & ex_aluop==2'b10 & ex_funct7==7'h01 & !flush.
- States: IDLE, BUSY, DONE.
- Reset (any state, mid-operation included): state=IDLE; counter, accumulators, md_result, md_rd = 0; md_done=0; md_busy=0.
- IDLE:
  - On start, capture op_a, op_b, funct3, ex_rd.
  - Normal op: form magnitudes (signed ops negate negative operands; MULHSU treats only op_a as signed) and record result sign; counter=31; go to BUSY.
  - DIV/DIVU/REM/REMU with op_b==0: go to DONE with quotient=32'hFFFFFFFF, remainder=op_a.
  - DIV/REM with op_a==32'h80000000 and op_b==32'hFFFFFFFF: go to DONE with quotient=32'h80000000, remainder=0.
- BUSY:
  - Each cycle performs one shift-add (multiply, 64-bit product) or one restoring shift-subtract (divide) step.
  - When counter==0 the step completes and state goes to DONE; otherwise counter decrements.
- DONE:
  - md_done=1 for one cycle.
  - md_result selects:
    - MUL: low 32 bits of the product.
    - MULH/MULHSU/MULHU: high 32 bits of the product, conditionally negated as 64 bits.
    - DIV/DIVU: quotient; quotient is negated if sign(a)^sign(b) for DIV.
    - REM/REMU: remainder; remainder takes the sign of op_a for REM.
  - Next state is IDLE unconditionally. start is ignored in DONE.
- Latency: normal op has md_done high in the cycle after the 33rd rising edge following the IDLE cycle where start was seen (1 capture + 32 iterations). The fast path has md_done in the cycle after the capture edge.
- md_stall = start | (state==BUSY). It is low in DONE, so the pipeline advances and EX/MEM captures md_result at the end of the DONE cycle.
- Back-to-back: the next M instruction enters ID/EX at the DONE edge and is seen in IDLE the following cycle. There is no lost stall coverage.
- Captured operands are frozen; op_a/op_b changes during BUSY have no effect.
- flush: in BUSY or DONE, the next state is IDLE, md_done is forced 0 that cycle and no result is produced. In IDLE, flush blocks start.
- Simultaneous rst and flush: rst wins.
- md_rd and md_result hold their last value outside DONE. Consumers qualify them with md_done.

Decomposition:
- Shared package `rv32_pkg`:
  - Constants: ALUOP_RTYPE=2'b10, FUNCT7_MULDIV=7'h01.
  - funct3 encodings F3_MUL..F3_REMU.
  - State encoding MD_IDLE/MD_BUSY/MD_DONE.
- One natural sub-module: `muldiv_step`, a combinational single-iteration datapath (add/shift or subtract/restore). The FSM, counter and sign fix-up stay in `ex_muldiv_unit`.

Test Plan:
- MUL op_a=7, op_b=32'hFFFFFFFD -> md_stall high 33 cycles, md_done 1 cycle, md_result=32'hFFFFFFEB, md_rd=ex_rd.
- MULHU 32'hFFFFFFFF*32'hFFFFFFFF -> 32'hFFFFFFFE. MULH same operands -> 0. MULHSU 32'hFFFFFFFF,32'hFFFFFFFF -> 32'hFFFFFFFF.
- DIV -7/2 -> 32'hFFFFFFFD; REM -7/2 -> 32'hFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 32'hFFFFFFFF and REM 5/0 -> 5, each with md_done one cycle after capture. DIV 32'h80000000/-1 -> 32'h80000000, REM -> 0, fast path.
- flush asserted on BUSY cycle 10 -> state IDLE next cycle, md_done never asserted, md_stall low. rst on BUSY cycle 5 -> all outputs 0 next cycle.
- Back-to-back MUL then DIVU with op_a/op_b changed mid-BUSY -> two md_done pulses, results from the captured operands, no gap in stall coverage.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 decode constants and the multiply/divide engine state encoding.
package rv32_pkg;

   localparam logic [1:0] ALUOP_RTYPE   = 2'b10;
   localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   // All divide/remainder encodings have funct3[2] set.
   function automatic logic f3_is_div(input logic [2:0] f3);
      return f3[2];
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// Multiply: {i_hi,i_lo} is the partial product with the multiplier in i_lo.
// Divide:   i_hi is the partial remainder, i_lo shifts dividend out / quotient in.
module muldiv_step
   import rv32_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_is_div,
   input  logic [XLEN-1:0] i_hi,
   input  logic [XLEN-1:0] i_lo,
   input  logic [XLEN-1:0] i_opnd,
   output logic [XLEN-1:0] o_hi,
   output logic [XLEN-1:0] o_lo
);

   logic [XLEN:0] w_sum;
   logic [XLEN:0] w_rem_sh;
   logic [XLEN:0] w_diff;
   logic          w_fits;

   assign w_sum    = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
   assign w_rem_sh = {i_hi, i_lo[XLEN-1]};
   assign w_diff   = w_rem_sh - {1'b0, i_opnd};
   // Shifted remainder is below 2*divisor, so the top bit is exactly the borrow.
   assign w_fits   = ~w_diff[XLEN];

   // Select the multiply or divide iteration result.
   always_comb begin
      if (i_is_div) begin
         o_hi = w_fits ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
         o_lo = {i_lo[XLEN-2:0], w_fits};
      end else begin
         o_hi = w_sum[XLEN:1];
         o_lo = {w_sum[0], i_lo[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine in EX; stalls the front end while busy
// and presents a single-cycle result pulse to the EX result mux.
module ex_muldiv_unit
   import rv32_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic [1:0]      ex_aluop,
   input  logic [6:0]      ex_funct7,
   input  logic [2:0]      ex_funct3,
   input  logic [4:0]      ex_rd,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            md_stall,
   output logic            md_done,
   output logic [XLEN-1:0] md_result,
   output logic [4:0]      md_rd,
   output logic            md_busy
);

   localparam logic [XLEN-1:0] L_MIN = {1'b1, {(XLEN-1){1'b0}}};

   md_state_e        r_state, w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_funct3;
   logic [4:0]       r_rd;
   logic [XLEN-1:0]  r_opnd, r_hi, r_lo;
   logic             r_neg_q, r_neg_r;
   logic [XLEN-1:0]  r_result;
   logic [4:0]       r_md_rd;

   logic            w_start, w_is_div, w_a_signed, w_b_signed;
   logic            w_a_neg, w_b_neg, w_b_zero, w_ovf, w_busy_is_div;
   logic [XLEN-1:0] w_mag_a, w_mag_b, w_step_hi, w_step_lo;
   logic [XLEN-1:0] w_mulh_neg, w_final;

   // Decode of the instruction currently in ID/EX.
   assign w_start    = (r_state == MD_IDLE) && (ex_aluop == ALUOP_RTYPE) &&
                       (ex_funct7 == FUNCT7_MULDIV) && !flush;
   assign w_is_div   = f3_is_div(ex_funct3);
   assign w_a_signed = (ex_funct3 == F3_MULH) || (ex_funct3 == F3_MULHSU) ||
                       (ex_funct3 == F3_DIV)  || (ex_funct3 == F3_REM);
   assign w_b_signed = (ex_funct3 == F3_MULH) || (ex_funct3 == F3_DIV) ||
                       (ex_funct3 == F3_REM);
   assign w_a_neg    = w_a_signed && op_a[XLEN-1];
   assign w_b_neg    = w_b_signed && op_b[XLEN-1];
   assign w_mag_a    = w_a_neg ? -op_a : op_a;
   assign w_mag_b    = w_b_neg ? -op_b : op_b;
   assign w_b_zero   = (op_b == '0);
   assign w_ovf      = ((ex_funct3 == F3_DIV) || (ex_funct3 == F3_REM)) &&
                       (op_a == L_MIN) && (op_b == '1);

   assign w_busy_is_div = f3_is_div(r_funct3);

   muldiv_step #(.XLEN(XLEN)) u_step (
      .i_is_div (w_busy_is_div),
      .i_hi     (r_hi),
      .i_lo     (r_lo),
      .i_opnd   (r_opnd),
      .o_hi     (w_step_hi),
      .o_lo     (w_step_lo)
   );

   // High half of the two's-complement negation of the 64-bit product.
   assign w_mulh_neg = ~r_hi + {{(XLEN-1){1'b0}}, (r_lo == '0)};

   // Sign fix-up and result selection from the finished accumulators.
   always_comb begin
      w_final = r_lo;
      case (r_funct3)
         F3_MUL:                       w_final = r_lo;
         F3_MULH, F3_MULHSU, F3_MULHU: w_final = r_neg_q ? w_mulh_neg : r_hi;
         F3_DIV, F3_DIVU:              w_final = r_neg_q ? -r_lo : r_lo;
         default:                      w_final = r_neg_r ? -r_hi : r_hi;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (rst) r_state <= MD_IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default first so no branch leaves the signal unassigned (no latch).
      w_next_state = r_state;
      case (r_state)
         MD_IDLE: if (w_start) w_next_state = (w_is_div && (w_b_zero || w_ovf)) ?
                                              MD_DONE : MD_BUSY;
         MD_BUSY: if (flush)            w_next_state = MD_IDLE;
                  else if (r_cnt == '0) w_next_state = MD_DONE;
         MD_DONE: w_next_state = MD_IDLE;
         default: w_next_state = MD_IDLE;
      endcase
   end

   // Outputs; result and rd hold the last completed op outside the done pulse.
   always_comb begin
      md_stall  = w_start || (r_state == MD_BUSY);
      md_busy   = (r_state != MD_IDLE);
      md_done   = (r_state == MD_DONE) && !flush;
      md_result = md_done ? w_final : r_result;
      md_rd     = md_done ? r_rd    : r_md_rd;
   end

   // Operand capture, iteration datapath and completed-result hold registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_funct3 <= '0;
         r_rd     <= '0;
         r_opnd   <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_result <= '0;
         r_md_rd  <= '0;
      end else begin
         case (r_state)
            MD_IDLE: if (w_start) begin
               r_funct3 <= ex_funct3;
               r_rd     <= ex_rd;
               r_cnt    <= CNT_W'(XLEN - 1);
               r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
               if (w_is_div && w_b_zero) begin
                  r_hi    <= op_a;
                  r_lo    <= '1;
                  r_neg_q <= 1'b0;
                  r_neg_r <= 1'b0;
               end else if (w_is_div && w_ovf) begin
                  r_hi    <= '0;
                  r_lo    <= L_MIN;
                  r_neg_q <= 1'b0;
                  r_neg_r <= 1'b0;
               end else begin
                  r_hi    <= '0;
                  r_lo    <= w_is_div ? w_mag_a : w_mag_b;
                  r_neg_q <= w_a_neg ^ w_b_neg;
                  r_neg_r <= w_is_div && w_a_neg;
               end
            end
            MD_BUSY: begin
               r_hi <= w_step_hi;
               r_lo <= w_step_lo;
               if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            end
            MD_DONE: if (md_done) begin
               r_result <= w_final;
               r_md_rd  <= r_rd;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed cases plus randomized ops
// compared against a plain-arithmetic RV32M reference model.
module tb_ex_muldiv_unit;
   import rv32_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush;
   logic [1:0]  ex_aluop;
   logic [6:0]  ex_funct7;
   logic [2:0]  ex_funct3;
   logic [4:0]  ex_rd;
   logic [31:0] op_a, op_b;
   logic        md_stall, md_done, md_busy;
   logic [31:0] md_result;
   logic [4:0]  md_rd;

   int          n_total = 0;
   int          n_pass  = 0;
   logic [31:0] last_res = '0;
   logic [4:0]  last_rd  = '0;

   always #5 clk = ~clk;

   ex_muldiv_unit dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .ex_aluop  (ex_aluop),
      .ex_funct7 (ex_funct7),
      .ex_funct3 (ex_funct3),
      .ex_rd     (ex_rd),
      .op_a      (op_a),
      .op_b      (op_b),
      .md_stall  (md_stall),
      .md_done   (md_done),
      .md_result (md_result),
      .md_rd     (md_rd),
      .md_busy   (md_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // RV32M semantics computed with wide integer arithmetic.
   function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
      logic signed [63:0] sa, sb, ub_s;
      logic [63:0]        ua, ub, p;
      logic               ovf;
      sa   = {{32{a[31]}}, a};
      sb   = {{32{b[31]}}, b};
      ua   = {32'b0, a};
      ub   = {32'b0, b};
      ub_s = $signed(ub);
      ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p    = '0;
      case (f3)
         3'd0: begin p = sa * sb;   return p[31:0];  end
         3'd1: begin p = sa * sb;   return p[63:32]; end
         3'd2: begin p = sa * ub_s; return p[63:32]; end
         3'd3: begin p = ua * ub;   return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf)    return 32'h8000_0000;
            return $signed(a) / $signed(b);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf)    return 32'h0;
            return $signed(a) % $signed(b);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   // Issue one M op, wait (bounded) for the done pulse and check it.
   task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input bit scramble);
      logic [31:0] exp;
      int          lat, cyc, stalls;
      bit          fast;
      exp  = ref_md(f3, a, b);
      fast = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      lat  = fast ? 1 : 33;
      @(posedge clk); #1;
      ex_aluop  = 2'b10;
      ex_funct7 = 7'h01;
      ex_funct3 = f3;
      ex_rd     = rd;
      op_a      = a;
      op_b      = b;
      cyc       = 0;
      stalls    = 0;
      @(negedge clk);
      while (md_done !== 1'b1 && cyc < 100) begin
         if (md_stall === 1'b1) stalls++;
         @(posedge clk);
         cyc++;
         if (scramble && cyc == 10) begin
            #1;
            op_a = $urandom;
            op_b = $urandom;
         end
         @(negedge clk);
      end
      check({name, " latency"}, 32'(cyc), 32'(lat));
      check({name, " stall cycles"}, 32'(stalls), 32'(lat));
      check({name, " done"}, {31'b0, md_done}, 32'd1);
      check({name, " result"}, md_result, exp);
      check({name, " rd"}, {27'b0, md_rd}, {27'b0, rd});
      check({name, " stall in done"}, {31'b0, md_stall}, 32'd0);
      last_res = exp;
      last_rd  = rd;
   endtask

   // Retire the pipeline's M instruction and confirm the pulse ended and outputs hold.
   task automatic finish_idle(input string name);
      @(posedge clk); #1;
      ex_aluop = 2'b00;
      @(negedge clk);
      check({name, " done pulse ended"}, {31'b0, md_done}, 32'd0);
      check({name, " result held"}, md_result, last_res);
      check({name, " rd held"}, {27'b0, md_rd}, {27'b0, last_rd});
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dones;
      rst = 1'b1; flush = 1'b0;
      ex_aluop = '0; ex_funct7 = '0; ex_funct3 = '0; ex_rd = '0; op_a = '0; op_b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset busy",   {31'b0, md_busy},  32'd0);
      check("reset done",   {31'b0, md_done},  32'd0);
      check("reset stall",  {31'b0, md_stall}, 32'd0);
      check("reset result", md_result, 32'd0);
      check("reset rd",     {27'b0, md_rd}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed cases.
      do_op("MUL 7*-3", F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0);   finish_idle("MUL");
      do_op("MULHU -1*-1", F3_MULHU, '1, '1, 5'd6, 1'b0);             finish_idle("MULHU");
      do_op("MULH -1*-1", F3_MULH, '1, '1, 5'd7, 1'b0);               finish_idle("MULH");
      do_op("MULHSU -1*-1", F3_MULHSU, '1, '1, 5'd8, 1'b0);           finish_idle("MULHSU");
      do_op("DIV -7/2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b0);    finish_idle("DIV");
      do_op("REM -7/2", F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b0);   finish_idle("REM");
      do_op("DIVU 100/7", F3_DIVU, 32'd100, 32'd7, 5'd11, 1'b0);      finish_idle("DIVU");
      do_op("REMU 100/7", F3_REMU, 32'd100, 32'd7, 5'd12, 1'b0);      finish_idle("REMU");
      do_op("DIV 5/0", F3_DIV, 32'd5, 32'd0, 5'd13, 1'b0);            finish_idle("DIV0");
      do_op("REM 5/0", F3_REM, 32'd5, 32'd0, 5'd14, 1'b0);            finish_idle("REM0");
      do_op("DIV ovf", F3_DIV, 32'h8000_0000, '1, 5'd15, 1'b0);       finish_idle("DIVOVF");
      do_op("REM ovf", F3_REM, 32'h8000_0000, '1, 5'd16, 1'b0);       finish_idle("REMOVF");

      // Flush on BUSY cycle 10 aborts the op.
      @(posedge clk); #1;
      ex_aluop = 2'b10; ex_funct7 = 7'h01; ex_funct3 = F3_MUL; ex_rd = 5'd20;
      op_a = 32'd3; op_b = 32'd9;
      repeat (10) @(posedge clk);
      #1;
      flush = 1'b1; ex_aluop = 2'b00;
      @(negedge clk);
      check("flush busy done", {31'b0, md_done}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush busy to idle", {31'b0, md_busy},  32'd0);
      check("flush busy stall",   {31'b0, md_stall}, 32'd0);
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (md_done === 1'b1) dones++;
      end
      check("flush no done", 32'(dones), 32'd0);
      check("flush result held", md_result, last_res);

      // Flush during DONE suppresses the pulse.
      @(posedge clk); #1;
      ex_aluop = 2'b10; ex_funct3 = F3_DIV; ex_rd = 5'd21; op_a = 32'd5; op_b = 32'd0;
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      check("flush done pulse", {31'b0, md_done}, 32'd0);
      check("flush done result held", md_result, last_res);
      @(posedge clk); #1;
      flush = 1'b0; ex_aluop = 2'b00;
      @(negedge clk);
      check("flush done to idle", {31'b0, md_busy}, 32'd0);

      // Flush in IDLE blocks start.
      @(posedge clk); #1;
      ex_aluop = 2'b10; ex_funct3 = F3_MUL; flush = 1'b1;
      @(negedge clk);
      check("flush idle stall", {31'b0, md_stall}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0; ex_aluop = 2'b00;
      @(negedge clk);
      check("flush idle no start", {31'b0, md_busy}, 32'd0);

      // Back-to-back with operands changing mid-BUSY.
      do_op("b2b MUL", F3_MUL, 32'd1234, 32'd5678, 5'd22, 1'b1);
      do_op("b2b DIVU", F3_DIVU, 32'd1_000_000, 32'd37, 5'd23, 1'b1);
      finish_idle("b2b");

      // Randomized ops against the reference model.
      for (int i = 0; i < 20; i++) begin
         do_op("rnd", 3'($urandom_range(0, 7)), pick(), pick(),
               5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)));
         finish_idle("rnd");
      end

      // Reset on BUSY cycle 5 clears everything.
      do_op("pre-reset MUL", F3_MUL, 32'd3, 32'd5, 5'd25, 1'b0);
      finish_idle("pre-reset");
      @(posedge clk); #1;
      ex_aluop = 2'b10; ex_funct3 = F3_DIVU; ex_rd = 5'd26; op_a = 32'd99; op_b = 32'd4;
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1; flush = 1'b1; ex_aluop = 2'b00;
      @(posedge clk); #1;
      rst = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("rst busy",   {31'b0, md_busy},  32'd0);
      check("rst done",   {31'b0, md_done},  32'd0);
      check("rst stall",  {31'b0, md_stall}, 32'd0);
      check("rst result", md_result, 32'd0);
      check("rst rd",     {27'b0, md_rd}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
